// File: rtl/jpeg_block_scheduler.sv
// jpeg_block_scheduler
// Walks the MCU grid of one JPEG frame and, inside each MCU, the component
// blocks for 4:4:4 or 4:2:0. It hands one block command at a time to the
// shared dequantise/IDCT/colour-convert datapath over valid/ready, and it caps
// the number of blocks in flight using the datapath's per-block completion pulse.

module jpeg_block_scheduler #(
  parameter int MCU_W   = 8,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [MCU_W-1:0] mcus_x,
  input  logic [MCU_W-1:0] mcus_y,
  input  logic             mode_420,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_comp,
  output logic             cmd_qsel,
  output logic [2:0]       cmd_blk,
  output logic [MCU_W-1:0] cmd_mcu_x,
  output logic [MCU_W-1:0] cmd_mcu_y,
  input  logic             blk_done,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);

  localparam int OW = $clog2(MAX_OUT + 1);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_next;

  // Latched frame geometry: the last column and last row index, with 0 mapped to 1 MCU.
  logic [MCU_W-1:0] x_max, y_max;
  logic             m420;

  // Position of the command currently being offered.
  logic [2:0]       blk;
  logic [MCU_W-1:0] x, y;

  logic [OW-1:0] outstanding, outstanding_next;

  logic start_ok;
  logic hs;
  logic blk_wrap, x_wrap, y_wrap, frame_last;
  logic done_ok;

  // Abort outranks start, so a start in the same cycle as abort is dropped.
  assign start_ok   = (state == S_IDLE) && start && !abort;
  assign hs         = cmd_valid && cmd_ready;
  assign blk_wrap   = m420 ? (blk == 3'd5) : (blk == 3'd2);
  assign x_wrap     = (x == x_max);
  assign y_wrap     = (y == y_max);
  assign frame_last = blk_wrap && x_wrap && y_wrap;
  assign done_ok    = blk_done && (outstanding != '0);

  // Issue is gated only by registered state, so a completion re-opens the window one cycle later.
  assign cmd_valid = (state == S_ISSUE) && (outstanding < MAX_CNT);

  assign cmd_blk   = blk;
  assign cmd_mcu_x = x;
  assign cmd_mcu_y = y;

  // Map the block index to its component and quantisation table for the active mode.
  always_comb begin
    cmd_comp = 2'd0;
    if (m420) begin
      if (blk == 3'd4) begin
        cmd_comp = 2'd1;
      end else if (blk == 3'd5) begin
        cmd_comp = 2'd2;
      end
    end else begin
      cmd_comp = blk[1:0];
    end
    cmd_qsel = (cmd_comp != 2'd0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs; abort overrides whatever the state would do.
  always_comb begin
    state_next = state;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ok) begin
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (hs && frame_last) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outstanding_next == '0) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if (abort) begin
      state_next = S_IDLE;
    end
  end

  // Geometry capture on start, then block/x/y advance on every handshake except the
  // final one, so the fields keep showing the last block after the frame is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_max <= '0;
      y_max <= '0;
      m420  <= 1'b0;
      blk   <= 3'd0;
      x     <= '0;
      y     <= '0;
    end else if (start_ok) begin
      x_max <= (mcus_x == '0) ? '0 : mcus_x - 1'b1;
      y_max <= (mcus_y == '0) ? '0 : mcus_y - 1'b1;
      m420  <= mode_420;
      blk   <= 3'd0;
      x     <= '0;
      y     <= '0;
    end else if (!abort && hs && !frame_last) begin
      if (blk_wrap) begin
        blk <= 3'd0;
        if (x_wrap) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end else begin
        blk <= blk + 3'd1;
      end
    end
  end

  // In-flight count: a handshake and a completion in the same cycle cancel out.
  always_comb begin
    outstanding_next = outstanding;
    if (hs && !done_ok) begin
      outstanding_next = outstanding + OW'(1);
    end else if (!hs && done_ok) begin
      outstanding_next = outstanding - OW'(1);
    end
  end

  // In-flight count register; abort forgets everything already issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (abort) begin
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_next;
    end
  end

  // Sticky error for a completion that has no matching issued block; a new frame clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start_ok) begin
      err <= 1'b0;
    end else if (blk_done && (outstanding == '0)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jpeg_block_scheduler.sv
// Testbench for jpeg_block_scheduler: expected commands are queued when a frame
// is started and matched against each handshake (and each stalled cycle).

module tb_jpeg_block_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] mcus_x;
  logic [7:0] mcus_y;
  logic       mode_420;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_comp;
  logic       cmd_qsel;
  logic [2:0] cmd_blk;
  logic [7:0] cmd_mcu_x;
  logic [7:0] cmd_mcu_y;
  logic       blk_done;
  logic       busy;
  logic       frame_done;
  logic       err;

  jpeg_block_scheduler #(.MCU_W(8), .MAX_OUT(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .mcus_x     (mcus_x),
    .mcus_y     (mcus_y),
    .mode_420   (mode_420),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_comp   (cmd_comp),
    .cmd_qsel   (cmd_qsel),
    .cmd_blk    (cmd_blk),
    .cmd_mcu_x  (cmd_mcu_x),
    .cmd_mcu_y  (cmd_mcu_y),
    .blk_done   (blk_done),
    .busy       (busy),
    .frame_done (frame_done),
    .err        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_count = 0;
  int fd_count = 0;
  int fd_cyc = -1;
  int last_done_cyc = -100;
  logic hs_seen = 1'b0;
  logic d1 = 1'b0;
  logic d2 = 1'b0;
  logic auto_done = 1'b0;
  logic manual_done = 1'b0;
  logic [31:0] sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    d2 = d1;
    d1 = auto_done && hs_seen;
    blk_done = (auto_done && d2) || manual_done;
    manual_done = 1'b0;
    if (blk_done) last_done_cyc = cyc;
  endtask

  task automatic pushFrame(input int mx, input int my, input bit m420);
    int ex, ey, nb, comp;
    logic [31:0] e;
    ex = (mx == 0) ? 1 : mx;
    ey = (my == 0) ? 1 : my;
    nb = m420 ? 6 : 3;
    for (int yy = 0; yy < ey; yy++) begin
      for (int xx = 0; xx < ex; xx++) begin
        for (int b = 0; b < nb; b++) begin
          if (m420) comp = (b < 4) ? 0 : ((b == 4) ? 1 : 2);
          else      comp = b;
          e = '0;
          e[21:20] = 2'(comp);
          e[19]    = (comp != 0);
          e[18:16] = 3'(b);
          e[15:8]  = 8'(xx);
          e[7:0]   = 8'(yy);
          sb_q.push_back(e);
        end
      end
    end
  endtask

  task automatic applyStimulus(input int mx, input int my, input bit m420);
    pushFrame(mx, my, m420);
    mcus_x   = 8'(mx);
    mcus_y   = 8'(my);
    mode_420 = m420;
    start    = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("valid_after_start", cmd_valid, 1);
  endtask

  task automatic waitHs(input int target, input int budget);
    for (int i = 0; i < budget && hs_count < target; i++) tick();
    checkOutput("hs_reached", hs_count, target);
  endtask

  task automatic waitFrame(input int budget);
    int fd0;
    fd0 = fd_count;
    for (int i = 0; i < budget && fd_count == fd0; i++) tick();
    checkOutput("frame_done_count", fd_count - fd0, 1);
    checkOutput("frame_done_time", fd_cyc, last_done_cyc + 1);
    checkOutput("idle_after_done", busy, 0);
    checkOutput("frame_done_width", frame_done, 0);
    checkOutput("sb_drained", sb_q.size(), 0);
    checkOutput("err_clean", err, 0);
  endtask

  // Monitor: compare the offered command with the queue head every valid cycle.
  initial begin
    logic [31:0] cur, exp;
    forever begin
      @(negedge clk);
      hs_seen = cmd_valid && cmd_ready;
      if (frame_done) begin
        fd_count++;
        fd_cyc = cyc;
      end
      if (cmd_valid) begin
        cur = {10'd0, cmd_comp, cmd_qsel, cmd_blk, cmd_mcu_x, cmd_mcu_y};
        exp = (sb_q.size() != 0) ? sb_q[0] : 32'hDEAD_BEEF;
        if (cmd_ready) begin
          checkOutput("cmd", cur, exp);
          hs_count++;
          if (sb_q.size() != 0) void'(sb_q.pop_front());
        end else begin
          checkOutput("cmd_hold", cur, exp);
        end
      end
    end
  end

  initial begin
    int h0, f0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mcus_x = '0; mcus_y = '0;
    mode_420 = 1'b0; cmd_ready = 1'b0; blk_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_valid", cmd_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_fields", {cmd_comp, cmd_qsel, cmd_blk, cmd_mcu_x, cmd_mcu_y}, 0);

    $display("[TB] 4:4:4 1x1 frame, then 0x0 geometry (treated as 1x1)");
    auto_done = 1'b1; cmd_ready = 1'b1;
    h0 = hs_count;
    applyStimulus(1, 1, 0);
    waitFrame(50);
    checkOutput("hs_444_1x1", hs_count - h0, 3);
    h0 = hs_count;
    applyStimulus(0, 0, 0);
    waitFrame(50);
    checkOutput("hs_444_0x0", hs_count - h0, 3);

    $display("[TB] 4:2:0 2x2 frame");
    h0 = hs_count;
    applyStimulus(2, 2, 1);
    waitFrame(200);
    checkOutput("hs_420_2x2", hs_count - h0, 24);

    $display("[TB] 4:2:0 1x1 frame with cmd_ready low for 5 cycles");
    h0 = hs_count;
    applyStimulus(1, 1, 1);
    tick(); tick();
    cmd_ready = 1'b0;
    repeat (5) tick();
    cmd_ready = 1'b1;
    waitFrame(100);
    checkOutput("hs_stall", hs_count - h0, 6);

    $display("[TB] withheld completions, then start during DRAIN");
    auto_done = 1'b0;
    h0 = hs_count;
    applyStimulus(1, 1, 0);
    waitHs(h0 + 2, 20);
    tick(); tick();
    checkOutput("window_full_valid", cmd_valid, 0);
    checkOutput("window_full_hs", hs_count - h0, 2);
    manual_done = 1'b1;
    tick();
    checkOutput("valid_same_cycle_done", cmd_valid, 0);
    tick();
    checkOutput("valid_after_done", cmd_valid, 1);
    tick();
    checkOutput("drain_busy", busy, 1);
    checkOutput("drain_valid", cmd_valid, 0);
    mcus_x = 8'd5; mcus_y = 8'd3; mode_420 = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    manual_done = 1'b1;
    tick();
    manual_done = 1'b1;
    tick();
    waitFrame(20);
    repeat (5) tick();
    checkOutput("drain_start_ignored_hs", hs_count - h0, 3);
    checkOutput("drain_start_ignored_busy", busy, 0);

    $display("[TB] abort with one block outstanding");
    cmd_ready = 1'b0;
    applyStimulus(2, 1, 0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb_q.delete();
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_valid", cmd_valid, 0);
    f0 = fd_count;
    repeat (4) tick();
    checkOutput("abort_no_frame_done", fd_count - f0, 0);
    checkOutput("abort_err_quiet", err, 0);
    manual_done = 1'b1;
    tick();
    tick();
    checkOutput("err_after_stray_done", err, 1);
    auto_done = 1'b1; cmd_ready = 1'b1;
    h0 = hs_count;
    applyStimulus(1, 1, 1);
    checkOutput("err_cleared_by_start", err, 0);
    waitFrame(100);
    checkOutput("hs_after_abort", hs_count - h0, 6);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
